// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
//   state_e     : arbiter FSM states
//   ID_W        : requester index width for the default two-requester build
//   DIV0_Q_BIT  : value replicated across every quotient bit on divide-by-zero
//   id_width()  : index width for an arbitrary requester count
package div_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned ID_W = 32'd1;

  // Divide-by-zero quotient is all-ones regardless of width or signedness.
  localparam logic DIV0_Q_BIT = 1'b1;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   grant : one-hot winner (zero when no request)
//   idx   : encoded winner index
//   any   : at least one request present
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 32'd2,
  parameter int unsigned IDX_W   = ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned cand_s;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 32'd0;
    for (int unsigned k = 32'd0; k < NUM_REQ; k++) begin
      cand_s = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = IDX_W'(cand_s);
        any           = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external iterative divider between NUM_REQ requesters.
//   req_*           : per-requester valid/ready request ports, packed payloads
//   flush           : discards the in-flight request (or blocks grants in IDLE)
//   rsp_*           : single tagged response port (valid/ready)
//   div_start/x/y/signed -> external divider; div_complete/s/r <- divider
// Divide-by-zero is answered locally: quotient all-ones, remainder = dividend.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 32'd2,
  parameter int unsigned DATA_W  = 32'd32,
  parameter int unsigned TAG_W   = 32'd4,
  localparam int unsigned RID_W  = id_width(NUM_REQ)
) (
  input  logic                      div_clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_signed,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic                      flush,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic                      div_start,
  output logic                      div_signed,
  output logic [DATA_W-1:0]         div_x,
  output logic [DATA_W-1:0]         div_y,
  input  logic                      div_complete,
  input  logic [DATA_W-1:0]         div_s,
  input  logic [DATA_W-1:0]         div_r
);

  state_e             state_q, state_d;
  logic [RID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               drop_q, drop_d;

  logic               div_signed_q;
  logic [DATA_W-1:0]  div_x_q, div_y_q;
  logic [RID_W-1:0]   rsp_id_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic [DATA_W-1:0]  rsp_q_q, rsp_r_q;

  logic [NUM_REQ-1:0] grant_s;
  logic [RID_W-1:0]   win_idx_s;
  logic               any_s;
  logic               hs_s;
  logic               win_sgn_s;
  logic [DATA_W-1:0]  win_x_s, win_y_s;
  logic [TAG_W-1:0]   win_tag_s;
  logic               win_y_zero_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (RID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (any_s)
  );

  // A grant only happens in IDLE with flush low; ready is exactly that condition.
  assign hs_s         = (state_q == ST_IDLE) && !flush && any_s;
  assign win_sgn_s    = req_signed[win_idx_s];
  assign win_x_s      = req_dividend[32'(win_idx_s) * DATA_W +: DATA_W];
  assign win_y_s      = req_divisor[32'(win_idx_s) * DATA_W +: DATA_W];
  assign win_tag_s    = req_tag[32'(win_idx_s) * TAG_W +: TAG_W];
  assign win_y_zero_s = (win_y_s == '0);

  // FSM state, round-robin pointer and flush-drop flag.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (hs_s) begin
          if (32'(win_idx_s) == NUM_REQ - 32'd1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = win_idx_s + RID_W'(1);
          end
          state_d = win_y_zero_s ? ST_RESP : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // The divider cannot abort: a flush only marks the result for discard.
        if (div_complete) begin
          state_d = (drop_q || flush) ? ST_IDLE : ST_RESP;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_RESP: begin
        // flush takes priority over a simultaneous rsp_ready.
        if (flush || rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          req_ready = grant_s;
        end else begin
          req_ready = '0;
        end
      end
      ST_BUSY: div_start = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: begin
        req_ready = '0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Operand/response registers: loaded on grant, result captured on completion.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      div_signed_q <= 1'b0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      rsp_id_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_q_q      <= '0;
      rsp_r_q      <= '0;
    end else if (hs_s) begin
      div_signed_q <= win_sgn_s;
      div_x_q      <= win_x_s;
      div_y_q      <= win_y_s;
      rsp_id_q     <= win_idx_s;
      rsp_tag_q    <= win_tag_s;
      if (win_y_zero_s) begin
        rsp_q_q <= {DATA_W{DIV0_Q_BIT}};
        rsp_r_q <= win_x_s;
      end
    end else if ((state_q == ST_BUSY) && div_complete) begin
      rsp_q_q <= div_s;
      rsp_r_q <= div_r;
    end
  end

  assign div_signed    = div_signed_q;
  assign div_x         = div_x_q;
  assign div_y         = div_y_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_quotient  = rsp_q_q;
  assign rsp_remainder = rsp_r_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed requests, an emulated divider,
// and a transaction-level model compared against the DUT every cycle.
module tb_div_arbiter;

  localparam int NR      = 2;
  localparam int DW      = 32;
  localparam int TW      = 4;
  localparam int DIV_LAT = 4;   // cycles div_start is high before completion

  logic              div_clk = 1'b0;
  logic              resetn  = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, req_signed;
  logic [NR*DW-1:0]  req_dividend, req_divisor;
  logic [NR*TW-1:0]  req_tag;
  logic              flush, rsp_valid, rsp_ready;
  logic [0:0]        rsp_id;
  logic [TW-1:0]     rsp_tag;
  logic [DW-1:0]     rsp_quotient, rsp_remainder;
  logic              div_start, div_signed;
  logic [DW-1:0]     div_x, div_y;
  logic              div_complete;
  logic [DW-1:0]     div_s, div_r;

  always #5 div_clk = ~div_clk;

  div_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAG_W(TW)) dut (
    .div_clk(div_clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .div_start(div_start), .div_signed(div_signed),
    .div_x(div_x), .div_y(div_y), .div_complete(div_complete),
    .div_s(div_s), .div_r(div_r)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic meaning of a request, including the local divide-by-zero rule.
  function automatic void ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    int c;
    for (int k = 0; k < NR; k++) begin
      c = (p + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- emulated external divider ----------------
  logic [31:0] dx, dy;
  bit          dsg, dbusy;
  int          dcnt;
  initial begin
    div_complete = 1'b0; div_s = '0; div_r = '0; dbusy = 1'b0; dcnt = 0;
    forever begin
      @(posedge div_clk); #2;
      if (!resetn) begin
        dbusy = 1'b0; div_complete = 1'b0;
      end else begin
        div_complete = 1'b0;
        if (dbusy) dcnt--;
        else if (div_start) begin
          dbusy = 1'b1; dcnt = DIV_LAT - 1; dx = div_x; dy = div_y; dsg = div_signed;
        end
        if (dbusy && dcnt == 0) begin
          ref_div(dsg, dx, dy, div_s, div_r);
          div_complete = 1'b1; dbusy = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  bit          m_inflight = 1'b0, m_div0, m_drop, m_done, m_sgn, m_rsp_seen;
  logic [31:0] m_x, m_y, m_q, m_r;
  logic [3:0]  m_tag;
  int          m_id, m_ptr = 0, cyc = 0, m_hs_cyc;
  logic [31:0] lg_q [64];
  logic [31:0] lg_r [64];
  logic [3:0]  lg_tag [64];
  int          lg_id [64];
  int          lg_n = 0;
  logic [NR-1:0] exp_rdy;
  int          w;
  bit          busy_m, resp_m;

  always @(negedge div_clk) begin
    cyc++;
    if (!resetn) begin
      m_inflight = 1'b0; m_ptr = 0; m_drop = 1'b0; m_done = 1'b0;
    end else begin
      busy_m = m_inflight && !m_div0 && !m_done;
      resp_m = m_inflight && (m_div0 || m_done);
      w = (!m_inflight && !flush) ? rr_pick(req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("div_start", div_start, busy_m);
      check("rsp_valid", rsp_valid, resp_m);
      if (busy_m) begin
        check("div_x", div_x, m_x);
        check("div_y", div_y, m_y);
        check("div_signed", div_signed, m_sgn);
      end
      if (resp_m) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_tag", rsp_tag, m_tag);
        check("rsp_quotient", rsp_quotient, m_q);
        check("rsp_remainder", rsp_remainder, m_r);
        if (!m_rsp_seen) begin
          check("latency", cyc - m_hs_cyc, m_div0 ? 1 : DIV_LAT + 1);
          m_rsp_seen = 1'b1;
        end
      end
      if (busy_m) begin
        if (flush) m_drop = 1'b1;
        if (div_complete) begin
          if (m_drop) m_inflight = 1'b0;
          else m_done = 1'b1;
        end
      end else if (resp_m) begin
        if (flush) m_inflight = 1'b0;
        else if (rsp_ready) begin
          m_inflight = 1'b0;
          lg_q[lg_n] = rsp_quotient; lg_r[lg_n] = rsp_remainder;
          lg_tag[lg_n] = rsp_tag; lg_id[lg_n] = int'(rsp_id);
          lg_n++;
        end
      end else if (w >= 0) begin
        m_inflight = 1'b1; m_id = w; m_sgn = req_signed[w];
        m_x = req_dividend[w*DW +: DW]; m_y = req_divisor[w*DW +: DW];
        m_tag = req_tag[w*TW +: TW];
        m_div0 = (m_y == 32'd0);
        ref_div(m_sgn, m_x, m_y, m_q, m_r);
        m_drop = 1'b0; m_done = 1'b0; m_rsp_seen = 1'b0;
        m_hs_cyc = cyc; m_ptr = (w + 1) % NR;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge div_clk); #1;
  endtask

  task automatic set_req(input int i, input bit sgn, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] t);
    req_signed[i] = sgn;
    req_dividend[i*DW +: DW] = x;
    req_divisor[i*DW +: DW]  = y;
    req_tag[i*TW +: TW]      = t;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (n < 60) begin
      @(negedge div_clk);
      if (req_ready[i] && req_valid[i]) break;
      n++;
    end
    check("grant_timeout", n >= 60, 1'b0);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_inflight || rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", n >= 100, 1'b0);
    tick();
  endtask

  task automatic check_all_zero(input string tagname);
    check({tagname, "_req_ready"}, req_ready, 2'b00);
    check({tagname, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tagname, "_div_start"}, div_start, 1'b0);
    check({tagname, "_div_signed"}, div_signed, 1'b0);
    check({tagname, "_div_x"}, div_x, 32'd0);
    check({tagname, "_div_y"}, div_y, 32'd0);
    check({tagname, "_rsp_id"}, rsp_id, 1'b0);
    check({tagname, "_rsp_tag"}, rsp_tag, 4'd0);
    check({tagname, "_rsp_q"}, rsp_quotient, 32'd0);
    check({tagname, "_rsp_r"}, rsp_remainder, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  g0, g1, n;
  bit  h0, h1;
  logic [31:0] held_q;

  initial begin
    req_valid = '0; req_signed = '0; req_dividend = '0; req_divisor = '0; req_tag = '0;
    flush = 1'b0; rsp_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Unsigned 100/7 from r0.
    set_req(0, 1'b0, 32'd100, 32'd7, 4'h3);
    wait_grant(0); wait_idle();
    check("t1_n", lg_n, 1);
    check("t1_id", lg_id[0], 0);
    check("t1_q", lg_q[0], 32'd14);
    check("t1_r", lg_r[0], 32'd2);

    // Signed -7/2 from r1.
    set_req(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'h5);
    wait_grant(1); wait_idle();
    check("t2_id", lg_id[1], 1);
    check("t2_q", lg_q[1], 32'hFFFF_FFFD);
    check("t2_r", lg_r[1], 32'hFFFF_FFFF);

    // Both requesters continuously valid: four ops.
    set_req(0, 1'b0, 32'd50, 32'd5, 4'hA);
    set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd16, 4'hC);
    g0 = 0; g1 = 0; n = 0;
    while ((g0 < 2 || g1 < 2) && n < 200) begin
      @(negedge div_clk);
      h0 = req_valid[0] && req_ready[0];
      h1 = req_valid[1] && req_ready[1];
      tick();
      if (h0) begin
        g0++;
        if (g0 == 1) set_req(0, 1'b0, 32'd9, 32'd4, 4'hB);
        else req_valid[0] = 1'b0;
      end
      if (h1) begin
        g1++;
        if (g1 == 1) set_req(1, 1'b0, 32'd1000, 32'd33, 4'hD);
        else req_valid[1] = 1'b0;
      end
      n++;
    end
    check("rr_timeout", n >= 200, 1'b0);
    wait_idle();
    check("rr_id0", lg_id[2], 0);
    check("rr_id1", lg_id[3], 1);
    check("rr_id2", lg_id[4], 0);
    check("rr_id3", lg_id[5], 1);
    check("rr_tag0", lg_tag[2], 4'hA);
    check("rr_tag1", lg_tag[3], 4'hC);
    check("rr_tag2", lg_tag[4], 4'hB);
    check("rr_tag3", lg_tag[5], 4'hD);
    check("rr_q1", lg_q[3], 32'h0FFF_FFFF);
    check("rr_r3", lg_r[5], 32'd10);

    // Divide by zero, unsigned and signed dividend.
    set_req(0, 1'b0, 32'h0000_1234, 32'd0, 4'h7);
    wait_grant(0); wait_idle();
    check("d0_q", lg_q[6], 32'hFFFF_FFFF);
    check("d0_r", lg_r[6], 32'h0000_1234);
    set_req(1, 1'b1, 32'hFFFF_FFFB, 32'd0, 4'h8);
    wait_grant(1); wait_idle();
    check("d0s_q", lg_q[7], 32'hFFFF_FFFF);
    check("d0s_r", lg_r[7], 32'hFFFF_FFFB);

    // Flush mid-BUSY: result discarded, no response.
    set_req(1, 1'b0, 32'd81, 32'd9, 4'h9);
    wait_grant(1);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_idle();
    check("flush_n", lg_n, 8);
    // Flush in IDLE blocks grants; request is taken once flush drops.
    flush = 1'b1;
    set_req(1, 1'b0, 32'd81, 32'd9, 4'hA);
    tick(); tick();
    flush = 1'b0;
    wait_grant(1); wait_idle();
    check("post_flush_tag", lg_tag[8], 4'hA);
    check("post_flush_q", lg_q[8], 32'd9);
    check("post_flush_r", lg_r[8], 32'd0);

    // Response stalled 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 32'd20, 32'd3, 4'hB);
    wait_grant(0);
    set_req(1, 1'b0, 32'd17, 32'd5, 4'hC);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("stall_timeout", n >= 50, 1'b0);
    held_q = rsp_quotient;
    repeat (5) tick();
    check("stall_valid", rsp_valid, 1'b1);
    check("stall_q", rsp_quotient, held_q);
    check("stall_n", lg_n, 9);
    rsp_ready = 1'b1;
    wait_grant(1); wait_idle();
    check("stall_q0", lg_q[9], 32'd6);
    check("stall_tag1", lg_tag[10], 4'hC);
    check("stall_q1", lg_q[10], 32'd3);

    // Reset mid-BUSY drops everything at once.
    set_req(0, 1'b0, 32'd1000, 32'd3, 4'hD);
    wait_grant(0);
    tick(); tick();
    check("pre_rst_start", div_start, 1'b1);
    #2;
    req_valid = '0;
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    set_req(0, 1'b0, 32'd9, 32'd2, 4'hE);
    wait_grant(0); wait_idle();
    check("final_n", lg_n, 12);
    check("final_q", lg_q[11], 32'd4);
    check("final_r", lg_r[11], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
